// File: rtl/serial_dft_stream.sv
// serial_dft_stream: N-point (4 or 8) DFT of a real sample stream using one
// time-shared complex MAC. Samples arrive over a valid/ready input, bins leave
// serially over a valid/ready output as rounded real/imaginary pairs.
module serial_dft_stream #(
    parameter int N       = 8,
    parameter int LOG2N   = 3,
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14,
    parameter int OUT_W   = DATA_W + LOG2N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_re,
    output logic [OUT_W-1:0]  out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    generate
        if (!((N == 4 && LOG2N == 2) || (N == 8 && LOG2N == 3))) begin : g_bad_n
            $error("serial_dft_stream: N must be 4 or 8, with LOG2N = log2(N)");
        end
    endgenerate

    localparam int TW_W   = TW_FRAC + 2;
    localparam int PROD_W = DATA_W + TW_W;
    localparam int ACC_W  = PROD_W + LOG2N;

    // Twiddle magnitudes in Q1.TW_FRAC; cos45 = round(2^TW_FRAC / sqrt(2)),
    // derived from the 16-bit fractional constant 46341 so that TW_FRAC=14
    // yields the exact table value 11585.
    localparam longint TW_ONE_L     = longint'(1) << TW_FRAC;
    localparam longint TW_C45_L     = (longint'(46341) * TW_ONE_L + longint'(32768)) >>> 16;
    localparam longint ROUND_HALF   = longint'(1) << (TW_FRAC - 1);
    localparam int     EIGHTHS_STEP = 8 / N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    localparam logic signed [TW_W-1:0] TW_ONE = TW_W'(TW_ONE_L);
    localparam logic signed [TW_W-1:0] TW_C45 = TW_W'(TW_C45_L);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t                    state;
    logic        [LOG2N-1:0]   cnt;
    logic        [LOG2N-1:0]   n_idx;
    logic        [LOG2N-1:0]   k_idx;
    logic        [LOG2N-1:0]   m_idx;
    logic        [LOG2N-1:0]   nxt_idx;
    logic        [2:0]         tw_e;
    logic signed [DATA_W-1:0]  x_buf  [N];
    logic signed [OUT_W-1:0]   bin_re [N];
    logic signed [OUT_W-1:0]   bin_im [N];
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [TW_W-1:0]    tw_c;
    logic signed [TW_W-1:0]    tw_s;
    logic signed [PROD_W-1:0]  prod_re;
    logic signed [PROD_W-1:0]  prod_im;
    logic signed [ACC_W-1:0]   acc_re;
    logic signed [ACC_W-1:0]   acc_im;
    logic signed [ACC_W-1:0]   acc_re_next;
    logic signed [ACC_W-1:0]   acc_im_next;

    // Cosine of e*45 degrees, e in eighths of a turn.
    function automatic logic signed [TW_W-1:0] tw_cos(input logic [2:0] e);
        case (e)
            3'd0: return TW_ONE;
            3'd1: return TW_C45;
            3'd2: return '0;
            3'd3: return -TW_C45;
            3'd4: return -TW_ONE;
            3'd5: return -TW_C45;
            3'd6: return '0;
            3'd7: return TW_C45;
        endcase
    endfunction

    // sin(theta) = cos(theta - 90 deg); the 3-bit subtraction wraps mod a turn.
    function automatic logic signed [TW_W-1:0] tw_sin(input logic [2:0] e);
        return tw_cos(e - 3'd2);
    endfunction

    // Round half up toward +inf, drop the twiddle fraction, keep OUT_W bits.
    function automatic logic signed [OUT_W-1:0] round_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = (a + ACC_W'(ROUND_HALF)) >>> TW_FRAC;
        return t[OUT_W-1:0];
    endfunction

    // (n*k) mod N falls out of the LOG2N-bit truncation; scale to eighths.
    assign m_idx       = n_idx * k_idx;
    assign tw_e        = 3'(int'(m_idx) * EIGHTHS_STEP);
    assign tw_c        = tw_cos(tw_e);
    assign tw_s        = tw_sin(tw_e);
    assign x_cur       = x_buf[n_idx];
    assign prod_re     = x_cur * tw_c;
    assign prod_im     = x_cur * tw_s;
    assign acc_re_next = acc_re + prod_re;
    assign acc_im_next = acc_im - prod_im;
    assign nxt_idx     = out_idx + 1'b1;

    // Control FSM, MAC accumulators and registered output fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            cnt       <= '0;
            n_idx     <= '0;
            k_idx     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (cnt == LAST) begin
                            state    <= S_COMPUTE;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            n_idx    <= '0;
                            k_idx    <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (n_idx == LAST) begin
                        acc_re <= '0;
                        acc_im <= '0;
                        n_idx  <= '0;
                        if (k_idx == LAST) begin
                            // bin 0 was finished N*(N-1) cycles ago, so it can be
                            // presented on the same edge the last bin is stored.
                            state     <= S_OUTPUT;
                            k_idx     <= '0;
                            out_valid <= 1'b1;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            out_re    <= bin_re[0];
                            out_im    <= bin_im[0];
                        end else begin
                            k_idx <= k_idx + 1'b1;
                        end
                    end else begin
                        acc_re <= acc_re_next;
                        acc_im <= acc_im_next;
                        n_idx  <= n_idx + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (out_idx == LAST) begin
                            state     <= S_LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_last <= (nxt_idx == LAST);
                            out_re   <= bin_re[nxt_idx];
                            out_im   <= bin_im[nxt_idx];
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Sample and bin storage; contents are overwritten each frame, so no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid && in_ready) begin
            x_buf[cnt] <= signed'(in_data);
        end
        if (state == S_COMPUTE && n_idx == LAST) begin
            bin_re[k_idx] <= round_out(acc_re_next);
            bin_im[k_idx] <= round_out(acc_im_next);
        end
    end

endmodule
